// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer
// Step sequencer for one Karplus-Strong string voice. A small note table is
// stepped through at a programmable tempo; each step drives the string's
// period, drum/string select, pluck and freeze controls.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_we_i/addr/data    note-table write port, entry = {rest, drum, period}
//   start_i, stop_i       start at step 0 (IDLE only) / abort (any state)
//   loop_en_i             wrap to step 0 after the last step
//   len_i, tempo_i        last step index and step length, captured at start
//   pluck_o, period_o, drum_string_no, freeze_o   string controls
//   step_o, step_pulse_o, busy_o                  sequencer status
module ks_note_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_LENGTH   = 4,
    parameter int STEPS        = 8,
    parameter int TEMPO_WIDTH  = 16,
    parameter int PLUCK_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_we_i,
    input  logic [$clog2(STEPS)-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH+1:0]    cfg_data_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_en_i,
    input  logic [$clog2(STEPS)-1:0] len_i,
    input  logic [TEMPO_WIDTH-1:0]   tempo_i,
    output logic                     pluck_o,
    output logic [DATA_WIDTH-1:0]    period_o,
    output logic                     drum_string_no,
    output logic                     freeze_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic                     step_pulse_o,
    output logic                     busy_o
);
    localparam int AW = $clog2(STEPS);
    localparam int EW = DATA_WIDTH + 2;
    // Shortest legal step: pluck pulse plus LOAD plus one low cycle.
    localparam logic [TEMPO_WIDTH-1:0] MIN_LEN = TEMPO_WIDTH'(PLUCK_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, LOAD, PLUCK, HOLD, REST} state_t;

    state_t                   state_reg, state_next;
    logic [AW-1:0]            step_reg, step_next;
    logic [AW-1:0]            last_reg, last_next;
    logic [TEMPO_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [TEMPO_WIDTH-1:0]   end_reg, end_next;
    logic                     pluck_reg, pluck_next;
    logic                     freeze_reg, freeze_next;
    logic                     pulse_reg, pulse_next;
    logic                     busy_reg, busy_next;
    logic [DATA_WIDTH-1:0]    period_reg, period_next;
    logic                     drum_reg, drum_next;
    logic [AW-1:0]            step_out_reg, step_out_next;

    logic [EW-1:0]            table_reg [STEPS];
    logic [EW-1:0]            entry;
    logic [DATA_WIDTH-1:0]    period_clamped;
    logic [TEMPO_WIDTH-1:0]   tempo_floor;

    // Note table: one register per entry so that every entry clears on reset.
    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_table
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    table_reg[gi] <= '0;
                end else if (cfg_we_i && cfg_addr_i == AW'(gi)) begin
                    table_reg[gi] <= cfg_data_i;
                end
            end
        end
    endgenerate

    // LOAD reads the pre-edge contents, so a same-cycle write is seen next visit.
    assign entry = table_reg[step_reg];

    always_comb begin
        period_clamped = entry[DATA_WIDTH-1:0];
        if (entry[DATA_WIDTH-1:0] == '0) begin
            period_clamped = DATA_WIDTH'(1);
        end else if (entry[DATA_WIDTH-1:0] > DATA_WIDTH'(MAX_LENGTH)) begin
            period_clamped = DATA_WIDTH'(MAX_LENGTH);
        end
    end

    assign tempo_floor = (tempo_i > MIN_LEN) ? tempo_i : MIN_LEN;

    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        last_next     = last_reg;
        cnt_next      = cnt_reg + 1'b1;
        end_next      = end_reg;
        pluck_next    = 1'b0;
        freeze_next   = 1'b0;
        pulse_next    = 1'b0;
        period_next   = period_reg;
        drum_next     = drum_reg;
        step_out_next = step_out_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = LOAD;
                    step_next  = '0;
                    last_next  = len_i;
                    end_next   = tempo_floor - 1'b1;
                end
            end
            LOAD: begin
                period_next   = period_clamped;
                drum_next     = entry[DATA_WIDTH];
                step_out_next = step_reg;
                pulse_next    = 1'b1;
                // LOAD is count 0 of the step, so the next cycle is count 1.
                cnt_next      = TEMPO_WIDTH'(1);
                if (entry[DATA_WIDTH+1]) begin
                    state_next  = REST;
                    freeze_next = 1'b1;
                end else begin
                    state_next = PLUCK;
                    pluck_next = 1'b1;
                end
            end
            PLUCK: begin
                if (cnt_reg == TEMPO_WIDTH'(PLUCK_CYCLES)) begin
                    state_next = HOLD;
                end else begin
                    pluck_next = 1'b1;
                end
            end
            HOLD, REST: begin
                // Freeze covers the whole rest step including the next LOAD cycle.
                freeze_next = (state_reg == REST);
                if (cnt_reg == end_reg) begin
                    if (step_reg != last_reg) begin
                        state_next = LOAD;
                        step_next  = step_reg + 1'b1;
                    end else if (loop_en_i) begin
                        state_next = LOAD;
                        step_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (stop_i) begin
            state_next = IDLE;
        end

        busy_next = (state_reg != IDLE) && (state_next != IDLE);

        // Entering IDLE silences the string controls but keeps the last note.
        if (state_next == IDLE) begin
            pluck_next    = 1'b0;
            freeze_next   = 1'b0;
            pulse_next    = 1'b0;
            period_next   = period_reg;
            drum_next     = drum_reg;
            step_out_next = step_out_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            step_reg     <= '0;
            last_reg     <= '0;
            cnt_reg      <= '0;
            end_reg      <= '0;
            pluck_reg    <= 1'b0;
            freeze_reg   <= 1'b0;
            pulse_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            period_reg   <= DATA_WIDTH'(1);
            drum_reg     <= 1'b0;
            step_out_reg <= '0;
        end else begin
            state_reg    <= state_next;
            step_reg     <= step_next;
            last_reg     <= last_next;
            cnt_reg      <= cnt_next;
            end_reg      <= end_next;
            pluck_reg    <= pluck_next;
            freeze_reg   <= freeze_next;
            pulse_reg    <= pulse_next;
            busy_reg     <= busy_next;
            period_reg   <= period_next;
            drum_reg     <= drum_next;
            step_out_reg <= step_out_next;
        end
    end

    assign pluck_o        = pluck_reg;
    assign freeze_o       = freeze_reg;
    assign step_pulse_o   = pulse_reg;
    assign busy_o         = busy_reg;
    assign period_o       = period_reg;
    assign drum_string_no = drum_reg;
    assign step_o         = step_out_reg;

endmodule
